// File: rtl/contactor_sequencer.sv
// Contactor sequencer: synchronises SPI-domain requests into clk and actuates one
// contactor coil at a time, confirming router feedback and enforcing a settle gap.
module contactor_sequencer #(
  parameter int N_CONTACTORS   = 21,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SETTLE_CYCLES  = 1000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CONTACTORS-1:0]   spi_requests,
  input  logic [2*N_CONTACTORS-1:0] router_feedback,
  input  logic                      clear_errors,
  input  logic                      force_open,
  output logic [N_CONTACTORS-1:0]   contactor_drive,
  output logic [N_CONTACTORS-1:0]   contactor_status,
  output logic                      feedback_timeout_error,
  output logic                      invalid_request,
  output logic [N_CONTACTORS-1:0]   fault_mask,
  output logic                      busy
);

  localparam int MAX_CNT = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int TW      = $clog2(MAX_CNT + 1);
  localparam int IW      = (N_CONTACTORS > 1) ? $clog2(N_CONTACTORS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_FB, SETTLE} state_e;

  state_e                  state_q, state_d;
  logic [N_CONTACTORS-1:0] sync_q [SYNC_STAGES];
  logic [N_CONTACTORS-1:0] req_s;
  logic [N_CONTACTORS-1:0] drive_q, drive_d, status_q, status_d, fault_q, fault_d;
  logic [N_CONTACTORS-1:0] fb_closed, fb_open, open_cand, close_cand;
  logic [TW-1:0]           timer_q, timer_d;
  logic [IW-1:0]           cur_idx_q, cur_idx_d, cand_idx;
  logic                    target_q, target_d, cand_found;
  logic                    timeout_err_q, timeout_err_d, invalid_q, invalid_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= spi_requests;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    for (int i = 0; i < N_CONTACTORS; i++) begin
      fb_closed[i] = (router_feedback[2*i +: 2] == 2'b10);
      fb_open[i]   = (router_feedback[2*i +: 2] == 2'b01);
    end
  end

  // Opens beat closes; scanning downward lets the lowest index win each class.
  always_comb begin
    open_cand  = drive_q & ~req_s & ~fault_q;
    close_cand = ~drive_q & req_s & ~fault_q;
    cand_found = (|open_cand) || (|close_cand);
    cand_idx   = '0;
    for (int i = N_CONTACTORS-1; i >= 0; i--)
      if (close_cand[i]) cand_idx = IW'(i);
    if (|open_cand) begin
      for (int i = N_CONTACTORS-1; i >= 0; i--)
        if (open_cand[i]) cand_idx = IW'(i);
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path infers a latch.
    state_d       = state_q;
    drive_d       = drive_q;
    timer_d       = timer_q;
    cur_idx_d     = cur_idx_q;
    target_d      = target_q;
    status_d      = drive_q & fb_closed;
    fault_d       = clear_errors ? '0 : fault_q;
    timeout_err_d = timeout_err_q & ~clear_errors;
    invalid_d     = (invalid_q & ~clear_errors) | (|(req_s & fault_q));

    if (force_open) begin
      drive_d = '0;
      state_d = IDLE;
      timer_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cand_found) begin
            drive_d[cand_idx] = ~drive_q[cand_idx];
            target_d          = ~drive_q[cand_idx];
            cur_idx_d         = cand_idx;
            timer_d           = '0;
            state_d           = WAIT_FB;
          end
        end
        WAIT_FB: begin
          timer_d = timer_q + TW'(1);
          if (target_q ? fb_closed[cur_idx_q] : fb_open[cur_idx_q]) begin
            state_d = SETTLE;
            timer_d = '0;
          end else if (timer_q == TW'(TIMEOUT_CYCLES-1)) begin
            drive_d[cur_idx_q] = 1'b0;
            fault_d[cur_idx_q] = 1'b1;
            timeout_err_d      = 1'b1;
            state_d            = SETTLE;
            timer_d            = '0;
          end
        end
        SETTLE: begin
          if (timer_q == TW'(SETTLE_CYCLES-1)) begin
            state_d = IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      drive_q       <= '0;
      status_q      <= '0;
      fault_q       <= '0;
      timer_q       <= '0;
      cur_idx_q     <= '0;
      target_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      invalid_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      drive_q       <= drive_d;
      status_q      <= status_d;
      fault_q       <= fault_d;
      timer_q       <= timer_d;
      cur_idx_q     <= cur_idx_d;
      target_q      <= target_d;
      timeout_err_q <= timeout_err_d;
      invalid_q     <= invalid_d;
    end
  end

  assign contactor_drive        = drive_q;
  assign contactor_status       = status_q;
  assign fault_mask             = fault_q;
  assign feedback_timeout_error = timeout_err_q;
  assign invalid_request        = invalid_q;
  assign busy                   = (state_q != IDLE);

endmodule
